// File: rtl/operand2_shift_pipe_pkg.sv
// Shared mode/shift-type encodings and the stage-1 decode bundle
// for the operand-2 shifter pipeline.
package operand2_shift_pipe_pkg;

    localparam logic [2:0] AM_ROTIMM = 3'b000;
    localparam logic [2:0] AM_REG    = 3'b001;
    localparam logic [2:0] AM_ZEXT   = 3'b010;
    localparam logic [2:0] AM_IMMSH  = 3'b011;
    localparam logic [2:0] AM_REGSH  = 3'b100;
    localparam logic [2:0] AM_SEXT   = 3'b101;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int AMT_BITS = 9;

    typedef struct packed {
        logic [2:0]          mode;
        logic [AMT_BITS-1:0] amt;
        logic [1:0]          shType;
        logic                rrx;
        logic                cin;
    } s1_decode_t;

    function automatic logic isReserved(input logic [2:0] mode);
        return (mode == 3'b110) || (mode == 3'b111);
    endfunction

endpackage

// File: rtl/operand2_shift_pipe_shift_core.sv
// Combinational ARM-style barrel shifter: LSL/LSR/ASR/ROR by a normalised
// amount, plus RRX, producing the shifted value and the shifter carry-out.
module shift_core
    import operand2_shift_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]    value_i,
    input  logic [AMT_BITS-1:0] amt_i,
    input  logic [1:0]          shType_i,
    input  logic                rrx_i,
    input  logic                cin_i,
    output logic [WIDTH-1:0]    n_o,
    output logic                c_o
);

    localparam int                  SHW    = $clog2(WIDTH);
    localparam logic [AMT_BITS-1:0] AMT_W  = AMT_BITS'(WIDTH);
    localparam logic [SHW-1:0]      SH_ONE = SHW'(1);

    logic [SHW-1:0]   sh;
    logic [SHW-1:0]   shNeg;
    logic [WIDTH-1:0] rot;
    logic             inRange;
    logic             atWidth;

    // shNeg is WIDTH-sh modulo WIDTH: the LSL carry index and the ROR back-shift.
    assign sh      = amt_i[SHW-1:0];
    assign shNeg   = SHW'(0) - sh;
    assign rot     = (value_i >> sh) | (value_i << shNeg);
    assign inRange = (amt_i < AMT_W);
    assign atWidth = (amt_i == AMT_W);

    always_comb begin
        n_o = value_i;
        c_o = cin_i;
        if (rrx_i) begin
            n_o = {cin_i, value_i[WIDTH-1:1]};
            c_o = value_i[0];
        end else if (amt_i != '0) begin
            case (shType_i)
                SH_LSL: begin
                    if (inRange) begin
                        n_o = value_i << sh;
                        c_o = value_i[shNeg];
                    end else begin
                        n_o = '0;
                        c_o = atWidth ? value_i[0] : 1'b0;
                    end
                end
                SH_LSR: begin
                    if (inRange) begin
                        n_o = value_i >> sh;
                        c_o = value_i[sh - SH_ONE];
                    end else begin
                        n_o = '0;
                        c_o = atWidth ? value_i[WIDTH-1] : 1'b0;
                    end
                end
                SH_ASR: begin
                    if (inRange) begin
                        n_o = $signed(value_i) >>> sh;
                        c_o = value_i[sh - SH_ONE];
                    end else begin
                        n_o = {WIDTH{value_i[WIDTH-1]}};
                        c_o = value_i[WIDTH-1];
                    end
                end
                default: begin
                    // A multiple of WIDTH leaves rot == value, so C lands on value[WIDTH-1].
                    n_o = rot;
                    c_o = rot[WIDTH-1];
                end
            endcase
        end
    end

endmodule

// File: rtl/operand2_shift_pipe.sv
// Two-stage operand-2 generator: S1 decodes the addressing mode into a shift
// request, S2 runs the shift core and holds N/C/err behind a valid/ready port.
module operand2_shift_pipe
    import operand2_shift_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_am,
    input  logic [WIDTH-1:0] in_rm,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [11:0]      in_i,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_n,
    output logic             out_c,
    output logic             out_err
);

    s1_decode_t       dec;
    s1_decode_t       s1Dec_q, s1Dec_d;
    logic [WIDTH-1:0] decValue;
    logic [WIDTH-1:0] s1Value_q, s1Value_d;
    logic             s1Valid_q, s1Valid_d;
    logic             outValid_q, outValid_d;
    logic [WIDTH-1:0] outN_q, outN_d;
    logic             outC_q, outC_d;
    logic             outErr_q, outErr_d;
    logic             s2Advance;
    logic [WIDTH-1:0] coreN;
    logic             coreC;
    logic             unusedRsBits;

    assign unusedRsBits = ^in_rs[WIDTH-1:8];
    assign s2Advance    = !outValid_q || out_ready;
    assign in_ready     = !s1Valid_q || s2Advance;

    // Every mode becomes (value, amount, type, rrx); non-shift modes are a zero-amount LSL.
    always_comb begin
        dec        = '0;
        dec.mode   = in_am;
        dec.cin    = in_cin;
        dec.shType = SH_LSL;
        decValue   = in_rm;
        case (in_am)
            AM_ROTIMM: begin
                decValue   = WIDTH'(in_i[7:0]);
                dec.amt    = AMT_BITS'({in_i[11:8], 1'b0});
                dec.shType = SH_ROR;
            end
            AM_REG:  decValue = in_rm;
            AM_ZEXT: decValue = WIDTH'(in_i);
            AM_IMMSH: begin
                dec.shType = in_i[6:5];
                dec.amt    = AMT_BITS'(in_i[11:7]);
                if (in_i[11:7] == 5'd0) begin
                    case (in_i[6:5])
                        SH_LSR, SH_ASR: dec.amt = AMT_BITS'(WIDTH);
                        SH_ROR:         dec.rrx = 1'b1;
                        default:        dec.amt = '0;
                    endcase
                end
            end
            AM_REGSH: begin
                dec.shType = in_i[6:5];
                dec.amt    = AMT_BITS'(in_rs[7:0]);
            end
            AM_SEXT: decValue = {{(WIDTH-12){in_i[11]}}, in_i};
            default: decValue = '0;
        endcase
    end

    shift_core #(.WIDTH(WIDTH)) u_shift_core (
        .value_i  (s1Value_q),
        .amt_i    (s1Dec_q.amt),
        .shType_i (s1Dec_q.shType),
        .rrx_i    (s1Dec_q.rrx),
        .cin_i    (s1Dec_q.cin),
        .n_o      (coreN),
        .c_o      (coreC)
    );

    always_comb begin
        s1Valid_d  = s1Valid_q;
        s1Dec_d    = s1Dec_q;
        s1Value_d  = s1Value_q;
        outValid_d = outValid_q;
        outN_d     = outN_q;
        outC_d     = outC_q;
        outErr_d   = outErr_q;
        if (in_ready) begin
            s1Valid_d = in_valid;
            if (in_valid) begin
                s1Dec_d   = dec;
                s1Value_d = decValue;
            end
        end
        if (s2Advance) begin
            outValid_d = s1Valid_q;
            if (s1Valid_q) begin
                outN_d   = coreN;
                outC_d   = coreC;
                outErr_d = isReserved(s1Dec_q.mode);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_q  <= 1'b0;
            s1Dec_q    <= '0;
            s1Value_q  <= '0;
            outValid_q <= 1'b0;
            outN_q     <= '0;
            outC_q     <= 1'b0;
            outErr_q   <= 1'b0;
        end else begin
            s1Valid_q  <= s1Valid_d;
            s1Dec_q    <= s1Dec_d;
            s1Value_q  <= s1Value_d;
            outValid_q <= outValid_d;
            outN_q     <= outN_d;
            outC_q     <= outC_d;
            outErr_q   <= outErr_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_n     = outN_q;
    assign out_c     = outC_q;
    assign out_err   = outErr_q;

endmodule

// File: tb/tb_operand2_shift_pipe.sv
// Scoreboard bench for operand2_shift_pipe: directed operand vectors,
// a stalled back-to-back burst and a reset with requests in flight.
module tb_operand2_shift_pipe;
    import operand2_shift_pipe_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        string            tag;
        logic [WIDTH-1:0] n;
        logic             c;
        logic             err;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_am = '0;
    logic [WIDTH-1:0] in_rm = '0;
    logic [WIDTH-1:0] in_rs = '0;
    logic [11:0]      in_i = '0;
    logic             in_cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_n;
    logic             out_c;
    logic             out_err;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount = 0;

    localparam logic [WIDTH-1:0] RM = 32'h8431FFEA;

    operand2_shift_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_am     (in_am),
        .in_rm     (in_rm),
        .in_rs     (in_rs),
        .in_i      (in_i),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n     (out_n),
        .out_c     (out_c),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    endtask

    // Drives one request from negedge+1, waits for in_ready, and returns just after the accepting edge with in_valid still high.
    task automatic applyStimulus(input string tag, input logic [2:0] am, input logic [WIDTH-1:0] rm,
                                 input logic [WIDTH-1:0] rs, input logic [11:0] imm, input logic cin,
                                 input logic [WIDTH-1:0] expN, input logic expC, input logic expErr);
        int   waitCycles;
        exp_t e;
        waitCycles = 0;
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_am    = am;
        in_rm    = rm;
        in_rs    = rs;
        in_i     = imm;
        in_cin   = cin;
        #1;
        while (!in_ready && waitCycles < 50) begin
            @(negedge clk);
            #2;
            waitCycles++;
        end
        if (in_ready) begin
            e.tag = tag;
            e.n   = expN;
            e.c   = expC;
            e.err = expErr;
            expQ.push_back(e);
        end else begin
            checkOutput({tag, ".acceptTimeout"}, 64'd0, 64'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag);
        int cycles;
        cycles = 0;
        while ((expQ.size() != 0 || out_valid) && cycles < 100) begin
            @(negedge clk);
            #3;
            cycles++;
        end
        checkOutput({tag, ".drain"}, 64'(expQ.size()), 64'd0);
    endtask

    // Output side: pops on every handshake and insists outputs hold while stalled.
    always begin : monitor
        exp_t             e;
        logic             stalled;
        logic [WIDTH-1:0] heldN;
        logic             heldC;
        logic             heldErr;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                stalled = 1'b0;
            end else begin
                if (stalled) begin
                    checkOutput("holdValid", 64'(out_valid), 64'd1);
                    checkOutput("holdN", 64'(out_n), 64'(heldN));
                    checkOutput("holdC", 64'(out_c), 64'(heldC));
                    checkOutput("holdErr", 64'(out_err), 64'(heldErr));
                end
                stalled = 1'b0;
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedOutput", 64'(out_n), 64'hDEAD);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput({e.tag, ".n"}, 64'(out_n), 64'(e.n));
                        checkOutput({e.tag, ".c"}, 64'(out_c), 64'(e.c));
                        checkOutput({e.tag, ".err"}, 64'(out_err), 64'(e.err));
                    end
                end else if (out_valid) begin
                    stalled = 1'b1;
                    heldN   = out_n;
                    heldC   = out_c;
                    heldErr = out_err;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rstOutValid", 64'(out_valid), 64'd0);
        checkOutput("rstOutN", 64'(out_n), 64'd0);
        checkOutput("rstOutC", 64'(out_c), 64'd0);
        checkOutput("rstOutErr", 64'(out_err), 64'd0);
        checkOutput("rstInReady", 64'(in_ready), 64'd1);
        reset = 1'b0;

        // Directed vectors, streamed back to back with the consumer always ready.
        applyStimulus("rotImm",    AM_ROTIMM, RM, 32'h0,  12'h26C, 1'b0, 32'hC0000006, 1'b1, 1'b0);
        applyStimulus("zextImm",   AM_ZEXT,   RM, 32'h0,  12'h26C, 1'b0, 32'h0000026C, 1'b0, 1'b0);
        applyStimulus("regPass",   AM_REG,    RM, 32'h0,  12'h26C, 1'b0, RM,           1'b0, 1'b0);
        applyStimulus("immRor4",   AM_IMMSH,  RM, 32'h0,  12'h26C, 1'b0, 32'hA8431FFE, 1'b1, 1'b0);
        applyStimulus("immAsr0",   AM_IMMSH,  RM, 32'h0,  12'h040, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        applyStimulus("immRrx",    AM_IMMSH,  RM, 32'h0,  12'h060, 1'b1, 32'hC218FFF5, 1'b0, 1'b0);
        applyStimulus("immLsl0",   AM_IMMSH,  RM, 32'h0,  12'h000, 1'b1, RM,           1'b1, 1'b0);
        applyStimulus("immLsr0",   AM_IMMSH,  RM, 32'h0,  12'h020, 1'b0, 32'h0,        1'b1, 1'b0);
        applyStimulus("immAsr1",   AM_IMMSH,  RM, 32'h0,  12'h0C0, 1'b0, 32'hC218FFF5, 1'b0, 1'b0);
        applyStimulus("regLsl32",  AM_REGSH,  RM, 32'h20, 12'h000, 1'b0, 32'h0,        1'b0, 1'b0);
        applyStimulus("regAmt0",   AM_REGSH,  RM, 32'h00, 12'h000, 1'b1, RM,           1'b1, 1'b0);
        applyStimulus("regLsr33",  AM_REGSH,  RM, 32'h21, 12'h020, 1'b0, 32'h0,        1'b0, 1'b0);
        applyStimulus("regRor64",  AM_REGSH,  RM, 32'h40, 12'h060, 1'b0, RM,           1'b1, 1'b0);
        applyStimulus("regLsr32",  AM_REGSH,  RM, 32'h20, 12'h020, 1'b0, 32'h0,        1'b1, 1'b0);
        applyStimulus("regAsr40",  AM_REGSH,  RM, 32'h28, 12'h040, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
        applyStimulus("regLsl4",   AM_REGSH,  RM, 32'h04, 12'h000, 1'b1, 32'h431FFEA0, 1'b0, 1'b0);
        applyStimulus("regLsr1",   AM_REGSH,  RM, 32'h01, 12'h020, 1'b1, 32'h4218FFF5, 1'b0, 1'b0);
        applyStimulus("regAsr4",   AM_REGSH,  RM, 32'h04, 12'h040, 1'b0, 32'hF8431FFE, 1'b1, 1'b0);
        applyStimulus("regRor36",  AM_REGSH,  RM, 32'h24, 12'h060, 1'b0, 32'hA8431FFE, 1'b1, 1'b0);
        applyStimulus("sextImm",   AM_SEXT,   RM, 32'h0,  12'h86C, 1'b0, 32'hFFFFF86C, 1'b0, 1'b0);
        applyStimulus("rotZero",   AM_ROTIMM, RM, 32'h0,  12'h0FF, 1'b1, 32'h000000FF, 1'b1, 1'b0);
        applyStimulus("reserved6", 3'b110,    RM, 32'h0,  12'h26C, 1'b0, 32'h0,        1'b0, 1'b1);
        applyStimulus("reserved7", 3'b111,    RM, 32'h0,  12'h26C, 1'b1, 32'h0,        1'b1, 1'b1);
        in_valid = 1'b0;
        waitDrain("directed");

        // Burst A, B, C against a stalled consumer: S1 must fill and in_ready must drop.
        @(negedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                applyStimulus("burstA", AM_REG, 32'h11111111, 32'h0, 12'h000, 1'b0, 32'h11111111, 1'b0, 1'b0);
                applyStimulus("burstB", AM_REG, 32'h22222222, 32'h0, 12'h000, 1'b1, 32'h22222222, 1'b1, 1'b0);
                applyStimulus("burstC", AM_REG, 32'h33333333, 32'h0, 12'h000, 1'b0, 32'h33333333, 1'b0, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                #2;
                checkOutput("stallInReady", 64'(in_ready), 64'd0);
                checkOutput("stallOutValid", 64'(out_valid), 64'd1);
                checkOutput("stallHoldsA", 64'(out_n), 64'h11111111);
                repeat (2) @(negedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        waitDrain("burst");

        // Reset with one request in S2 and one in S1; both must vanish.
        applyStimulus("flightX", AM_ROTIMM, RM, 32'h0, 12'h26C, 1'b0, 32'hC0000006, 1'b1, 1'b0);
        applyStimulus("flightY", AM_REG, 32'h55555555, 32'h0, 12'h000, 1'b1, 32'h55555555, 1'b1, 1'b0);
        in_valid = 1'b0;
        checkOutput("preRstValid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        expQ.delete();
        #1;
        checkOutput("midRstValid", 64'(out_valid), 64'd0);
        checkOutput("midRstN", 64'(out_n), 64'd0);
        checkOutput("midRstC", 64'(out_c), 64'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("postRstInReady", 64'(in_ready), 64'd1);
        checkOutput("postRstValid", 64'(out_valid), 64'd0);
        applyStimulus("fresh", AM_ZEXT, RM, 32'h0, 12'h123, 1'b0, 32'h00000123, 1'b0, 1'b0);
        in_valid = 1'b0;
        checkOutput("freshLat1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("freshLat2", 64'(out_valid), 64'd1);
        checkOutput("freshLat2N", 64'(out_n), 64'h123);
        waitDrain("fresh");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
